mem_datos_sync: RTL and testbench
=================================

Name: mem_datos_sync

Overview:
- Next-generation data memory for the datapath.
- Synchronous, word-organised RAM with:
  - a byte address;
  - byte/half/word access sizes;
  - sign/zero-extended loads;
  - a registered one-cycle read;
  - a valid/ready request handshake.
- Adds a post-reset zero-clear sequencer and alignment/range error reporting.
- Sits between the ALU address output and the write-back mux; replaces the combinational data memory.

Parameters:
- DEPTH, 64, number of 32-bit words. Must be a power of two, at least 2.
- ADDR_W, 32, width of the byte address port.
- CLEAR_ON_RESET, 1. When 1, memory is zeroed after reset. When 0, it is ready immediately and contents are kept.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  response is an error (misaligned, out of range, or illegal size)
- init_done  out  1  clear sequence finished

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
  - Clear counter = 0.
  - Memory contents are not touched by reset itself.
- State machine:
  - CLEAR:
    - Entered on reset when CLEAR_ON_RESET=1.
    - Writes 0 to word[cnt] each cycle, cnt 0..DEPTH-1.
    - req_ready=0 throughout.
    - After writing word DEPTH-1: go to RUN and set init_done=1.
    - Takes exactly DEPTH cycles.
  - RUN:
    - req_ready=1.
    - When CLEAR_ON_RESET=0, reset goes directly to RUN: req_ready=1 and init_done=1 from the first cycle after reset deasserts.
  - Reset asserted in any state, including mid-CLEAR, restarts from cnt=0. A partial clear is not resumed.
- Handshake:
  - A request is accepted on a clock edge where req_valid && req_ready.
  - At most one request per cycle. There is no back-pressure on the response.
  - Exactly one response follows each accepted request. rsp_valid is high in the cycle after acceptance, for one cycle.
  - Back-to-back requests give back-to-back responses (throughput 1 per cycle).
- Addressing:
  - word index = req_addr[log2(DEPTH)+1 : 2]; byte lane = req_addr[1:0]. Little-endian.
  - Error conditions, all checked in the acceptance cycle:
    - req_addr[ADDR_W-1 : log2(DEPTH)+2] nonzero: out of range.
    - Half access with addr[0]=1: misaligned.
    - Word access with addr[1:0]≠0: misaligned.
    - req_size=11: illegal size.
  - On any error: memory is not modified, rsp_err=1, rsp_rdata=0.
- Stores:
  - Byte lanes are written at the acceptance edge.
  - Byte writes lane addr[1:0] with wdata[7:0].
  - Half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Word writes all lanes.
  - Lanes not selected keep their value.
  - Response: rsp_err=0, rsp_rdata=0.
- Loads:
  - The word is read at the acceptance edge.
  - The selected byte/half is right-aligned, then sign- or zero-extended according to req_unsigned.
  - The result is registered into rsp_rdata. For a word load, req_unsigned is ignored.
- Hazard: a load accepted the cycle after a store to the same word returns the post-store data.
- Idle: when no request was accepted, rsp_valid=0, rsp_rdata=0, rsp_err=0.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings: SZ_BYTE, SZ_HALF, SZ_WORD;
  - state constants: ST_CLEAR, ST_RUN;
  - the function computing the per-lane write mask from size and addr[1:0].
- One sub-module, mem_load_align: purely combinational. It takes the word, addr[1:0], size and unsigned, and produces the extended 32-bit load value.
- The top level holds the array, the FSM/counter, the error check and the response registers.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=64:
  - req_ready is 0 for 64 cycles, then init_done=1 and req_ready=1.
  - A word load of every address returns 0x00000000.
- Store word 0xDEADBEEF at 0x10, then byte load at 0x13, signed and unsigned:
  - Signed returns 0xFFFFFFDE.
  - Unsigned returns 0x000000DE.
  - Half load signed at 0x10 returns 0xFFFFBEEF.
- Store byte 0x55 at 0x11 over 0xDEADBEEF, then word load at 0x10:
  - Returns 0xDEAD55EF.
  - The load is issued back-to-back with the store; rsp_valid is high for 2 consecutive cycles.
- Error cases:
  - Word store at 0x12: rsp_err=1.
  - Half load at 0x21: rsp_err=1.
  - Load at 0x100 with DEPTH=64: rsp_err=1.
  - req_size=11: rsp_err=1.
  - A following word load at 0x10 shows memory unchanged.
- Reset asserted at clear cycle 30:
  - The clear restarts, and init_done rises exactly 64 cycles after reset deasserts.
  - A previously written nonzero word reads 0.
- CLEAR_ON_RESET=0:
  - req_ready=1 in the first cycle after reset.
  - A word stored before a second reset still reads back its value after that reset.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and the store lane-mask helper for the data memory.
package mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Byte lanes touched by a store of the given size at the given lane offset
  function automatic logic [LANES-1:0] lane_mask(input size_e size, input logic [1:0] lane);
    logic [LANES-1:0] m;
    m = '0;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Right-aligns the selected byte/half of a memory word and extends it.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        lane,
  input  size_e             size,
  input  logic              uns,
  output logic [DATA_W-1:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Lane select followed by sign or zero extension
  always_comb begin
    byte_c = word[8*lane +: 8];
    half_c = lane[1] ? word[31:16] : word[15:0];
    data_c = word;
    case (size)
      SZ_BYTE: data_c = uns ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
      SZ_HALF: data_c = uns ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
      default: data_c = word;
    endcase
  end

endmodule

// File: rtl/mem_datos_sync.sv
// Synchronous byte-addressed data memory with post-reset clear and error reporting.
module mem_datos_sync
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH          = 64,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q;
  logic              clr_we_c, ready_d;

  size_e             size_c;
  logic [AW-1:0]     idx_c;
  logic [1:0]        lane_c;
  logic              acc_c, err_c, st_we_c;
  logic [LANES-1:0]  wmask_c;
  logic [DATA_W-1:0] bmask_c, wrep_c, rd_word_c, merged_c, ld_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_ON_RESET) state_q <= ST_CLEAR;
      else                state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave CLEAR after the last word has been zeroed
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // FSM outputs: clear-write strobe and next value of ready/done
  always_comb begin
    clr_we_c = 1'b0;
    ready_d  = 1'b0;
    if (state_q == ST_CLEAR && !reset) clr_we_c = 1'b1;
    if (state_d == ST_RUN) ready_d = 1'b1;
  end

  // Clear address counter
  always_ff @(posedge clk) begin
    if (reset)                   cnt_q <= '0;
    else if (state_q == ST_CLEAR) cnt_q <= cnt_q + AW'(1);
  end

  // Handshake status registers; init_done tracks ready since RUN is terminal
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      req_ready <= ready_d;
      init_done <= ready_d;
    end
  end

  // Request decode, error check and store-data merge
  always_comb begin
    size_c    = size_e'(req_size);
    idx_c     = req_addr[AW+1:2];
    lane_c    = req_addr[1:0];
    acc_c     = req_valid && req_ready && !reset;
    err_c     = ((req_addr >> (AW + 2)) != '0) ||
                (size_c == SZ_ILL) ||
                (size_c == SZ_HALF && lane_c[0]) ||
                (size_c == SZ_WORD && lane_c != 2'b00);
    st_we_c   = acc_c && req_we && !err_c;
    wmask_c   = lane_mask(size_c, lane_c);
    bmask_c   = {{8{wmask_c[3]}}, {8{wmask_c[2]}}, {8{wmask_c[1]}}, {8{wmask_c[0]}}};
    case (size_c)
      SZ_BYTE: wrep_c = {4{req_wdata[7:0]}};
      SZ_HALF: wrep_c = {2{req_wdata[15:0]}};
      default: wrep_c = req_wdata;
    endcase
    rd_word_c = mem[idx_c];
    merged_c  = (rd_word_c & ~bmask_c) | (wrep_c & bmask_c);
  end

  mem_load_align u_align (
    .word   (rd_word_c),
    .lane   (lane_c),
    .size   (size_c),
    .uns    (req_unsigned),
    .data_c (ld_c)
  );

  // Storage array: clear sequencer has priority, then accepted stores
  always_ff @(posedge clk) begin
    if (clr_we_c)     mem[cnt_q] <= '0;
    else if (st_we_c) mem[idx_c] <= merged_c;
  end

  // One-cycle response pulse with registered load data
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= acc_c;
      rsp_err   <= acc_c && err_c;
      rsp_rdata <= (acc_c && !req_we && !err_c) ? ld_c : '0;
    end
  end

endmodule

// File: tb/tb_mem_datos_sync.sv
// Scoreboard bench for mem_datos_sync (clearing instance plus a no-clear instance).
module tb_mem_datos_sync;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err, init_done;

  logic        r0_reset, r0_req_valid, r0_req_ready, r0_req_we, r0_req_unsigned;
  logic [31:0] r0_req_addr, r0_req_wdata, r0_rsp_rdata;
  logic [1:0]  r0_req_size;
  logic        r0_rsp_valid, r0_rsp_err, r0_init_done;

  int          checks = 0;
  int          failures = 0;
  int          b2b_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_e;
  logic [31:0] mdl[64];

  always #5 clk = ~clk;

  mem_datos_sync #(.DEPTH(64), .ADDR_W(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done)
  );

  mem_datos_sync #(.DEPTH(64), .ADDR_W(32), .CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .reset(r0_reset), .req_valid(r0_req_valid), .req_ready(r0_req_ready),
    .req_we(r0_req_we), .req_addr(r0_req_addr), .req_size(r0_req_size),
    .req_unsigned(r0_req_unsigned), .req_wdata(r0_req_wdata), .rsp_valid(r0_rsp_valid),
    .rsp_rdata(r0_rsp_rdata), .rsp_err(r0_rsp_err), .init_done(r0_init_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference load extraction: shift the addressed lane down, then extend
  function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input logic u);
    logic [31:0] s;
    s = w >> (8 * a);
    case (sz)
      B:       return u ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      H:       return u ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < 64; i++) mdl[i] = 32'h0;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd, input logic err,
                       input logic [31:0] data);
    logic [31:0] bm;
    @(negedge clk);
    chk("ready_at_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = sz;
    req_unsigned = u; req_wdata = wd;
    exp_q.push_back({err, data});
    if (we && !err) begin
      case (sz)
        B:       bm = 32'h0000_00FF << (8 * addr[1:0]);
        H:       bm = 32'h0000_FFFF << (8 * addr[1:0]);
        default: bm = 32'hFFFF_FFFF;
      endcase
      mdl[addr[7:2]] = (mdl[addr[7:2]] & ~bm) | ((wd << (8 * addr[1:0])) & bm);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_init(output int n);
    logic early;
    early = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (init_done) break;
      if (req_ready) early = 1'b1;
    end
    chk("ready_during_clear", 32'(early), 32'd0);
    chk("ready_after_clear", 32'(req_ready), 32'd1);
  endtask

  // Response monitor: pops the scoreboard on each response, idle outputs must be zero
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(exp_e[32]));
        chk("rsp_rdata", rsp_rdata, exp_e[31:0]);
      end
      if (prev_valid) b2b_cnt++;
    end else begin
      chk("idle_outputs", rsp_rdata | 32'(rsp_err), 32'd0);
    end
    prev_valid = rsp_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b0;
    logic [31:0] a, wd, ex;
    logic [1:0]  sz, ln;
    logic        we, u;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0;
    r0_reset = 1'b1; r0_req_valid = 1'b0; r0_req_we = 1'b0; r0_req_addr = '0;
    r0_req_size = '0; r0_req_unsigned = 1'b0; r0_req_wdata = '0;
    mdl_clear();

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);

    // Power-up clear takes exactly DEPTH cycles
    reset = 1'b0;
    wait_init(n);
    chk("clear_cycles", 32'(n), 32'd64);

    for (int i = 0; i < 64; i++) issue(1'b0, 32'(i * 4), W, 1'b0, 32'h0, 1'b0, 32'h0);

    issue(1'b1, 32'h10, W, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0);
    issue(1'b0, 32'h13, B, 1'b0, 32'h0, 1'b0, 32'hFFFFFFDE);
    issue(1'b0, 32'h13, B, 1'b1, 32'h0, 1'b0, 32'h000000DE);
    issue(1'b0, 32'h10, H, 1'b0, 32'h0, 1'b0, 32'hFFFFBEEF);
    issue(1'b0, 32'h12, H, 1'b1, 32'h0, 1'b0, 32'h0000DEAD);
    issue(1'b0, 32'h10, B, 1'b0, 32'h0, 1'b0, 32'hFFFFFFEF);
    issue(1'b0, 32'h10, W, 1'b1, 32'h0, 1'b0, 32'hDEADBEEF);
    idle();
    drain();

    // Store then load back-to-back to the same word
    b0 = b2b_cnt;
    issue(1'b1, 32'h11, B, 1'b0, 32'hFFFFFF55, 1'b0, 32'h0);
    issue(1'b0, 32'h10, W, 1'b0, 32'h0, 1'b0, 32'hDEAD55EF);
    idle();
    drain();
    chk("back_to_back_rsp", 32'(b2b_cnt - b0), 32'd1);

    issue(1'b1, 32'h14, W, 1'b0, 32'h11223344, 1'b0, 32'h0);
    issue(1'b1, 32'h16, H, 1'b0, 32'h9999ABCD, 1'b0, 32'h0);
    issue(1'b0, 32'h14, W, 1'b0, 32'h0, 1'b0, 32'hABCD3344);
    issue(1'b0, 32'h17, B, 1'b1, 32'h0, 1'b0, 32'h000000AB);

    // Error cases leave memory untouched
    issue(1'b1, 32'h12, W, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue(1'b0, 32'h21, H, 1'b0, 32'h0, 1'b1, 32'h0);
    issue(1'b0, 32'h100, W, 1'b0, 32'h0, 1'b1, 32'h0);
    issue(1'b0, 32'h10, X, 1'b0, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 32'h10, X, 1'b0, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 32'h80000010, W, 1'b0, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 32'h11, H, 1'b0, 32'h0, 1'b1, 32'h0);
    issue(1'b0, 32'h10, W, 1'b0, 32'h0, 1'b0, 32'hDEAD55EF);

    // Random aligned traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 2));
      ln = 2'($urandom_range(0, 3));
      if (sz == H) ln[0] = 1'b0;
      if (sz == W) ln = 2'b00;
      a  = {26'h0, 4'($urandom_range(0, 7)), ln};
      we = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      wd = $urandom();
      ex = we ? 32'h0 : mdl_load(mdl[a[7:2]], ln, sz, u);
      issue(we, a, sz, u, wd, 1'b0, ex);
    end
    idle();
    drain();

    // Reset in the middle of the clear restarts it from word 0
    issue(1'b1, 32'hF0, W, 1'b0, 32'h12345678, 1'b0, 32'h0);
    issue(1'b0, 32'hF0, W, 1'b0, 32'h0, 1'b0, 32'h12345678);
    idle();
    drain();
    reset = 1'b1;
    @(negedge clk);
    chk("done_in_reset", 32'(init_done), 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_init(n);
    chk("reclear_cycles", 32'(n), 32'd64);
    mdl_clear();
    issue(1'b0, 32'hF0, W, 1'b0, 32'h0, 1'b0, 32'h0);
    issue(1'b0, 32'h10, W, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    drain();

    // No-clear instance: ready at once and contents survive reset
    r0_reset = 1'b0;
    @(negedge clk);
    chk("r0_ready", 32'(r0_req_ready), 32'd1);
    chk("r0_done", 32'(r0_init_done), 32'd1);
    r0_req_valid = 1'b1; r0_req_we = 1'b1; r0_req_addr = 32'h24; r0_req_size = W;
    r0_req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    r0_req_valid = 1'b0;
    chk("r0_store_valid", 32'(r0_rsp_valid), 32'd1);
    chk("r0_store_err", 32'(r0_rsp_err), 32'd0);
    r0_reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("r0_ready_in_reset", 32'(r0_req_ready), 32'd0);
    r0_reset = 1'b0;
    @(negedge clk);
    chk("r0_ready_again", 32'(r0_req_ready), 32'd1);
    r0_req_valid = 1'b1; r0_req_we = 1'b0; r0_req_addr = 32'h24; r0_req_size = W;
    @(negedge clk);
    r0_req_valid = 1'b0;
    chk("r0_load_valid", 32'(r0_rsp_valid), 32'd1);
    chk("r0_load_data", r0_rsp_rdata, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
